// File: rtl/wb_write_scheduler.sv
// wb_write_scheduler: arbitrates the single register-file write port between
// the MEM/WB primary write and a secondary write (R15 result or other).
// Secondary writes that lose arbitration wait in a small in-order queue.
// The queue also supplies forwarding data to decode and drives stall.
//
// Optional build macro: WB_SCHED_ZERO_REG_EN
//   defined   -> writes to register 0 are discarded (no port cycle, no
//                enqueue, no invalidation) and rd_addr=0 never forwards.
//   undefined -> register 0 is an ordinary register.
//
// Handshake semantics: wb_valid and sec_valid are valid-only requests with
// no ready. Each is consumed in the cycle it is presented, either by the port
// or (secondary only) by the queue. Back-pressure is the registered stall,
// asserted with one slot of headroom so a request already in flight while
// the pipeline reacts still finds a free entry.
module wb_write_scheduler #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic              wb_sel_mem,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              sec_valid,
    input  logic [ADDR_W-1:0] sec_addr,
    input  logic [DATA_W-1:0] sec_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              stall,
    output logic [ADDR_W-1:0] q_count,
    output logic              overflow
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(QDEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(QDEPTH - 1);

    // Queue storage: entries live at head_q .. head_q+cnt_q-1 (mod QDEPTH).
    logic [ADDR_W-1:0] addr_q [QDEPTH];
    logic [DATA_W-1:0] data_q [QDEPTH];
    logic [QDEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_q, stall_d;
    logic              ovf_q, ovf_d;

    // Per-cycle decisions.
    logic wb_take;
    logic sec_take;
    logic rd_ok;
    logic q_empty;
    logic q_full;
    logic pop;
    logic bypass;
    logic push_req;
    logic push;
    logic drop;

`ifdef WB_SCHED_ZERO_REG_EN
    // Register 0 is hard-wired: such writes vanish before arbitration.
    assign wb_take  = wb_valid  && (wb_addr  != '0);
    assign sec_take = sec_valid && (sec_addr != '0);
    assign rd_ok    = (rd_addr != '0);
`else
    assign wb_take  = wb_valid;
    assign sec_take = sec_valid;
    assign rd_ok    = 1'b1;
`endif

    assign q_empty = (cnt_q == '0);
    assign q_full  = (cnt_q == CNT_FULL);

    // Port arbitration: primary, then queue head, then direct secondary bypass.
    always_comb begin
        pop      = 1'b0;
        bypass   = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_take) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_sel_mem ? mem_data : alu_data;
        end else if (!q_empty) begin
            // An invalidated head still pops, but takes no write.
            pop      = 1'b1;
            rf_we    = vld_q[head_q];
            rf_waddr = addr_q[head_q];
            rf_wdata = data_q[head_q];
        end else if (sec_take) begin
            bypass   = 1'b1;
            rf_we    = 1'b1;
            rf_waddr = sec_addr;
            rf_wdata = sec_data;
        end
        if (!rst) begin
            rf_we = 1'b0;
        end
    end

    // Enqueue decision and pointer/occupancy next state.
    always_comb begin
        push_req = sec_take && !bypass;
        push     = push_req && (!q_full || pop);
        drop     = push_req && q_full && !pop;
        head_d   = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d   = push ? tail_q + PTR_W'(1) : tail_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        stall_d = (cnt_d >= CNT_STALL);
        ovf_d   = ovf_q | drop;
    end

    // Valid-bit next state: older same-address entries are killed by a
    // primary write; the popped slot is cleared; the pushed slot is set last
    // so a same-cycle secondary write survives the primary it follows.
    always_comb begin
        vld_d = vld_q;
        if (wb_take) begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (addr_q[i] == wb_addr) begin
                    vld_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            vld_d[head_q] = 1'b0;
        end
        if (push) begin
            vld_d[tail_q] = 1'b1;
        end
    end

    // Forwarding: walk oldest to newest so the newest valid match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            if ((CNT_W'(k) < cnt_q) && rd_ok &&
                vld_q[head_q + PTR_W'(k)] &&
                (addr_q[head_q + PTR_W'(k)] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PTR_W'(k)];
            end
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
        end
    end

    // Queue payload write; contents are only meaningful under a valid bit.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= sec_addr;
            data_q[tail_q] <= sec_data;
        end
    end

    assign stall    = stall_q;
    assign overflow = ovf_q;
    assign q_count  = ADDR_W'(cnt_q);

endmodule

// File: tb/tb_wb_write_scheduler.sv
// Bench for wb_write_scheduler: directed scenarios followed by randomized
// traffic checked against a queue-based reference model.
module tb_wb_write_scheduler;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int QD = 4;

    logic          clk;
    logic          rst;
    logic          wb_valid;
    logic          wb_sel_mem;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] alu_data;
    logic [AW-1:0] wb_addr;
    logic          sec_valid;
    logic [AW-1:0] sec_addr;
    logic [DW-1:0] sec_data;
    logic [AW-1:0] rd_addr;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          stall;
    logic [AW-1:0] q_count;
    logic          overflow;

    int n_vec = 0;
    int n_err = 0;

    wb_write_scheduler #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_sel_mem(wb_sel_mem),
        .mem_data(mem_data), .alu_data(alu_data), .wb_addr(wb_addr),
        .sec_valid(sec_valid), .sec_addr(sec_addr), .sec_data(sec_data),
        .rd_addr(rd_addr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .stall(stall), .q_count(q_count), .overflow(overflow)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          vld;
    } ent_t;

    ent_t          mq[$];
    logic          m_stall = 1'b0;
    logic          m_ovf   = 1'b0;
    logic          e_we;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    logic          e_hit;
    logic [DW-1:0] e_fd;

    function automatic bit is_dropped_addr(input logic [AW-1:0] a);
`ifdef WB_SCHED_ZERO_REG_EN
        return (a == '0);
`else
        return 1'b0;
`endif
    endfunction

    // Expected combinational outputs for the current inputs and model queue.
    function automatic void model_comb();
        bit wt;
        bit st;
        wt = wb_valid  && !is_dropped_addr(wb_addr);
        st = sec_valid && !is_dropped_addr(sec_addr);
        e_we = 1'b0; e_wa = '0; e_wd = '0;
        if (wt) begin
            e_we = 1'b1; e_wa = wb_addr; e_wd = wb_sel_mem ? mem_data : alu_data;
        end else if (mq.size() > 0) begin
            e_we = mq[0].vld; e_wa = mq[0].addr; e_wd = mq[0].data;
        end else if (st) begin
            e_we = 1'b1; e_wa = sec_addr; e_wd = sec_data;
        end
        if (!rst) e_we = 1'b0;
        e_hit = 1'b0; e_fd = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].vld && mq[i].addr == rd_addr && !is_dropped_addr(rd_addr)) begin
                e_hit = 1'b1; e_fd = mq[i].data;
            end
        end
    endfunction

    // Model state advance at every active edge.
    always @(posedge clk) begin
        bit wt;
        bit st;
        bit direct;
        bit popped;
        if (!rst) begin
            mq.delete();
            m_stall = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            wt     = wb_valid  && !is_dropped_addr(wb_addr);
            st     = sec_valid && !is_dropped_addr(sec_addr);
            direct = !wt && (mq.size() == 0) && st;
            popped = !wt && (mq.size() > 0);
            if (wt) begin
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].addr == wb_addr) mq[i].vld = 1'b0;
            end
            if (popped) void'(mq.pop_front());
            if (st && !direct) begin
                if (mq.size() < QD) mq.push_back('{addr: sec_addr, data: sec_data, vld: 1'b1});
                else m_ovf = 1'b1;
            end
            m_stall = (mq.size() >= QD - 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit wv, input bit sel, input logic [DW-1:0] md,
                         input logic [DW-1:0] ad, input logic [AW-1:0] wa,
                         input bit sv, input logic [AW-1:0] sa,
                         input logic [DW-1:0] sd, input logic [AW-1:0] ra);
        wb_valid = wv; wb_sel_mem = sel; mem_data = md; alu_data = ad;
        wb_addr = wa; sec_valid = sv; sec_addr = sa; sec_data = sd; rd_addr = ra;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, '0, 0, '0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && q_count != 0; i++) begin
            idle();
            tick();
        end
        n_vec++;
        if (q_count !== 4'd0) begin
            n_err++; $display("FAIL drain: q_count %0d expected 0 within budget", q_count);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive(1, 0, 16'h1234, 16'h5678, 4'd2, 1, 4'd4, 16'h9999, '0);
        n_vec++;
        if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", rf_we); end
        tick(); tick();
        n_vec++;
        if (q_count !== 4'd0 || stall !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL reset_state: q_count=%0d stall=%b overflow=%b expected 0/0/0", q_count, stall, overflow);
        end
        rst = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_bypass();
        drive(0, 0, '0, '0, '0, 1, 4'd15, 16'hBEEF, '0);
        n_vec++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd15 || rf_wdata !== 16'hBEEF) begin
            n_err++; $display("FAIL bypass_port: we=%b addr=%0d data=%h expected 1/15/beef", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        idle();
        n_vec++;
        if (q_count !== 4'd0) begin n_err++; $display("FAIL bypass_count: got %0d expected 0", q_count); end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 16'hFFFF, 16'h0011, 4'd3, 1, 4'd15, 16'h0022, '0);
            n_vec++;
            if (rf_we !== 1'b1 || rf_waddr !== 4'd3 || rf_wdata !== 16'h0011) begin
                n_err++; $display("FAIL contention_primary: we=%b addr=%0d data=%h expected 1/3/0011", rf_we, rf_waddr, rf_wdata);
            end
            tick();
            n_vec++;
            if (q_count !== AW'(i + 1) || stall !== (i + 1 >= 3)) begin
                n_err++; $display("FAIL contention_fill: q_count=%0d stall=%b expected %0d/%b", q_count, stall, i + 1, (i + 1 >= 3));
            end
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            n_vec++;
            if (rf_we !== 1'b1 || rf_waddr !== 4'd15 || rf_wdata !== 16'h0022) begin
                n_err++; $display("FAIL contention_drain: we=%b addr=%0d data=%h expected 1/15/0022", rf_we, rf_waddr, rf_wdata);
            end
            tick();
        end
        n_vec++;
        if (q_count !== 4'd0 || stall !== 1'b0) begin
            n_err++; $display("FAIL contention_empty: q_count=%0d stall=%b expected 0/0", q_count, stall);
        end
    endtask

    task automatic test_waw();
        drive(1, 0, '0, 16'h0909, 4'd9, 1, 4'd5, 16'h0001, '0);
        tick();
        drive(1, 1, 16'h0002, 16'h7777, 4'd5, 0, '0, '0, '0);
        n_vec++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd5 || rf_wdata !== 16'h0002) begin
            n_err++; $display("FAIL waw_primary: we=%b addr=%0d data=%h expected 1/5/0002", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        idle();
        n_vec++;
        if (rf_we !== 1'b0) begin n_err++; $display("FAIL waw_stale_pop: we=%b expected 0", rf_we); end
        tick();
        n_vec++;
        if (q_count !== 4'd0) begin n_err++; $display("FAIL waw_count: got %0d expected 0", q_count); end
    endtask

    task automatic test_same_addr();
        drive(1, 0, '0, 16'h1111, 4'd6, 1, 4'd6, 16'h2222, '0);
        n_vec++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd6 || rf_wdata !== 16'h1111) begin
            n_err++; $display("FAIL same_addr_primary: we=%b addr=%0d data=%h expected 1/6/1111", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        idle();
        n_vec++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd6 || rf_wdata !== 16'h2222) begin
            n_err++; $display("FAIL same_addr_second: we=%b addr=%0d data=%h expected 1/6/2222", rf_we, rf_waddr, rf_wdata);
        end
        tick();
    endtask

    task automatic test_forwarding();
        drive(1, 0, '0, 16'h0101, 4'd1, 1, 4'd7, 16'hAAAA, 4'd7);
        n_vec++;
        if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_empty: hit=%b expected 0", fwd_hit); end
        tick();
        drive(1, 0, '0, 16'h0202, 4'd2, 1, 4'd7, 16'hBBBB, 4'd7);
        n_vec++;
        if (fwd_hit !== 1'b1 || fwd_data !== 16'hAAAA) begin
            n_err++; $display("FAIL fwd_same_cycle_push: hit=%b data=%h expected 1/aaaa", fwd_hit, fwd_data);
        end
        tick();
        drive(1, 0, '0, 16'h0404, 4'd4, 0, '0, '0, 4'd7);
        n_vec++;
        if (fwd_hit !== 1'b1 || fwd_data !== 16'hBBBB) begin
            n_err++; $display("FAIL fwd_newest: hit=%b data=%h expected 1/bbbb", fwd_hit, fwd_data);
        end
        rd_addr = 4'd8;
        #1;
        n_vec++;
        if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_miss: hit=%b expected 0", fwd_hit); end
        tick();
        drain();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, '0, 16'h0303, 4'd3, 1, AW'(10 + i), DW'(16'h00A0 + i), '0);
            tick();
            n_vec++;
            if (q_count !== AW'((i + 1 > QD) ? QD : i + 1) || overflow !== (i == 4)) begin
                n_err++; $display("FAIL overflow_fill: q_count=%0d overflow=%b expected %0d/%b",
                                  q_count, overflow, (i + 1 > QD) ? QD : i + 1, (i == 4));
            end
        end
`ifdef WB_SCHED_ZERO_REG_EN
        drive(1, 0, '0, 16'h5555, 4'd0, 0, '0, '0, '0);
        n_vec++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd10 || rf_wdata !== 16'h00A0) begin
            n_err++; $display("FAIL zero_reg_head: we=%b addr=%0d data=%h expected 1/10/00a0", rf_we, rf_waddr, rf_wdata);
        end
        tick();
`endif
        drain();
        n_vec++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_mid_queue();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, '0, 16'h0808, 4'd8, 1, AW'(1 + i), DW'(16'hC000 + i), '0);
            tick();
        end
        rst = 1'b0;
        idle();
        n_vec++;
        if (rf_we !== 1'b0) begin n_err++; $display("FAIL midreset_we: got %b expected 0", rf_we); end
        tick();
        rst = 1'b1;
        idle();
        n_vec++;
        if (q_count !== 4'd0 || stall !== 1'b0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL midreset_state: q_count=%0d stall=%b overflow=%b expected 0/0/0", q_count, stall, overflow);
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (rf_we !== 1'b0) begin n_err++; $display("FAIL midreset_no_issue: we=%b expected 0", rf_we); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 1), DW'($urandom), DW'($urandom),
                  AW'($urandom_range(0, 7)), $urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)),
                  DW'($urandom), AW'($urandom_range(0, 7)));
            model_comb();
            n_vec++;
            if (rf_we !== e_we || (e_we && (rf_waddr !== e_wa || rf_wdata !== e_wd))) begin
                n_err++; $display("FAIL rand_port @%0d: we=%b addr=%0d data=%h expected %b/%0d/%h",
                                  n, rf_we, rf_waddr, rf_wdata, e_we, e_wa, e_wd);
            end
            n_vec++;
            if (fwd_hit !== e_hit || (e_hit && fwd_data !== e_fd)) begin
                n_err++; $display("FAIL rand_fwd @%0d: hit=%b data=%h expected %b/%h", n, fwd_hit, fwd_data, e_hit, e_fd);
            end
            n_vec++;
            if (q_count !== AW'(mq.size()) || stall !== m_stall || overflow !== m_ovf) begin
                n_err++; $display("FAIL rand_state @%0d: q_count=%0d stall=%b overflow=%b expected %0d/%b/%b",
                                  n, q_count, stall, overflow, mq.size(), m_stall, m_ovf);
            end
            tick();
        end
        rst = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_bypass();
        test_contention();
        test_waw();
        test_same_addr();
        test_forwarding();
        test_overflow();
        test_reset_mid_queue();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
